// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - parallel request side and serial line of the UART TX framer
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            prescale;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, data_valid, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, data_valid, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART TX framer: start, LSB-first data, optional parity, stop
// Define UART_TX_TWO_STOP_EN for two stop bits; default build sends one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           RST,
  uart_tx_frame_if.slave tx_if
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            presc_q;
  logic [5:0]            edge_q;
  logic [3:0]            bit_cnt_q;
  logic                  tx_q;
  logic                  busy_q;

  logic [5:0]            presc_d;
  logic                  bit_done_d;

  // Prescale below 4 is clamped; anything larger is taken verbatim.
  assign presc_d    = (tx_if.prescale < 6'd4) ? 6'd4 : tx_if.prescale;
  assign bit_done_d = (edge_q == (presc_q - 6'd1));

  assign tx_if.TX_OUT = tx_q;
  assign tx_if.busy   = busy_q;

  // tx_q is loaded with the level of the state being entered, so the line
  // changes exactly on the bit boundary edge without a combinational output.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= 6'd0;
      edge_q    <= 6'd0;
      bit_cnt_q <= 4'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      edge_q    <= 6'd0;
      bit_cnt_q <= 4'd0;
      if (tx_if.data_valid) begin
        data_q    <= tx_if.P_DATA;
        par_en_q  <= tx_if.PAR_EN;
        par_typ_q <= tx_if.PAR_TYP;
        presc_q   <= presc_d;
        state_q   <= START;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
      end
    end else if (!bit_done_d) begin
      edge_q <= edge_q + 6'd1;
    end else begin
      edge_q <= 6'd0;
      case (state_q)
        START: begin
          state_q   <= DATA;
          bit_cnt_q <= 4'd0;
          shift_q   <= data_q;
          tx_q      <= data_q[0];
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= 4'd0;
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= (^data_q) ^ par_typ_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            shift_q   <= shift_q >> 1;
            tx_q      <= shift_q[1];
          end
        end
        PARITY: begin
          state_q   <= STOP;
          bit_cnt_q <= 4'd0;
          tx_q      <= 1'b1;
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            busy_q    <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame with a per-cycle line model
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif

  logic clk;
  logic RST;

  uart_tx_frame_if #(.DATA_WIDTH(8)) tx_if ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .RST   (RST),
    .tx_if (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected {busy, TX_OUT} for every cycle of the frame in flight.
  logic [1:0] mq[$];

  int busy_run = 0;
  int last_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame = start 0, data LSB first, optional parity, stop(s) 1; each bit presc cycles.
  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    int presc;
    int bits[$];
    presc = (ps < 4) ? 4 : int'(ps);
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
    if (pe) bits.push_back(int'((^d) ^ pt));
    for (int i = 0; i < SB; i++) bits.push_back(1);
    foreach (bits[b])
      for (int c = 0; c < presc; c++) mq.push_back({1'b1, bits[b][0]});
  endtask

  always @(posedge clk) begin
    if (RST) mq.delete();
    else if (mq.size() != 0) void'(mq.pop_front());
    else if (tx_if.data_valid) build_frame(tx_if.P_DATA, tx_if.PAR_EN, tx_if.PAR_TYP, tx_if.prescale);
  end

  always @(negedge clk) begin
    if (chk_en) check("line {busy,tx}", int'({tx_if.busy, tx_if.TX_OUT}),
                      int'((mq.size() != 0) ? mq[0] : 2'b01));
  end

  always @(negedge clk) begin
    if (tx_if.busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    tx_if.P_DATA = d;
    tx_if.PAR_EN = pe;
    tx_if.PAR_TYP = pt;
    tx_if.prescale = ps;
    tx_if.data_valid = 1'b1;
    @(negedge clk);
    tx_if.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tx_if.busy == 1'b0 && mq.size() == 0) break;
    end
    check(name, (k >= 3000) ? 1 : 0, 0);
    #1;
  endtask

  initial begin
    int a5_bits[11];
    a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

    RST = 1'b1;
    tx_if.P_DATA = 8'h00;
    tx_if.data_valid = 1'b0;
    tx_if.PAR_EN = 1'b0;
    tx_if.PAR_TYP = 1'b0;
    tx_if.prescale = 6'd8;
    repeat (3) @(negedge clk);
    check("reset tx", int'(tx_if.TX_OUT), 1);
    check("reset busy", int'(tx_if.busy), 0);
    RST = 1'b0;
    chk_en = 1'b1;

    // 0xA5, even parity, prescale 8: mid-bit samples against the hand-derived bit list.
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    check("model len a5", mq.size(), 80 + 8 * SB);
    repeat (4) @(negedge clk);
    for (int b = 0; b < 11; b++) begin
      check($sformatf("a5 bit %0d", b), int'(tx_if.TX_OUT), a5_bits[b]);
      repeat (8) @(negedge clk);
    end
    wait_idle("timeout a5");
    check("busy len a5", last_len, 80 + 8 * SB);

    // 0x00, odd parity: parity bit must be 1.
    send(8'h00, 1'b1, 1'b1, 6'd8);
    repeat (12) @(negedge clk);
    check("odd data bit0", int'(tx_if.TX_OUT), 0);
    repeat (64) @(negedge clk);
    check("odd parity bit", int'(tx_if.TX_OUT), 1);
    wait_idle("timeout odd");
    check("busy len odd", last_len, 80 + 8 * SB);

    // 0xFF, no parity, prescale 16.
    send(8'hFF, 1'b0, 1'b0, 6'd16);
    repeat (8) @(negedge clk);
    check("ff start", int'(tx_if.TX_OUT), 0);
    repeat (16) @(negedge clk);
    check("ff data", int'(tx_if.TX_OUT), 1);
    wait_idle("timeout ff");
    check("busy len ff", last_len, 144 + 16 * SB);

    // Request while busy is dropped; new P_DATA mid-frame must not leak in.
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    repeat (20) @(negedge clk);
    tx_if.P_DATA = 8'h3C;
    tx_if.prescale = 6'd4;
    tx_if.data_valid = 1'b1;
    @(negedge clk);
    tx_if.data_valid = 1'b0;
    wait_idle("timeout drop");
    check("busy len drop", last_len, 80 + 8 * SB);
    send(8'h3C, 1'b0, 1'b0, 6'd8);
    check("idle accept tx", int'(tx_if.TX_OUT), 0);
    check("idle accept busy", int'(tx_if.busy), 1);
    wait_idle("timeout 3c");
    check("busy len 3c", last_len, 72 + 8 * SB);

    // data_valid held high: back-to-back frames with a single idle cycle between.
    @(negedge clk);
    tx_if.P_DATA = 8'h01;
    tx_if.PAR_EN = 1'b0;
    tx_if.prescale = 6'd4;
    tx_if.data_valid = 1'b1;
    repeat (60) @(negedge clk);
    tx_if.data_valid = 1'b0;
    wait_idle("timeout b2b");
    check("busy len b2b", last_len, 36 + 4 * SB);

    // Reset during data bit 3 aborts the frame.
    send(8'h5A, 1'b1, 1'b0, 6'd8);
    repeat (34) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check("abort tx", int'(tx_if.TX_OUT), 1);
    check("abort busy", int'(tx_if.busy), 0);
    RST = 1'b0;
    send(8'h5A, 1'b1, 1'b0, 6'd8);
    wait_idle("timeout 5a");
    check("busy len 5a", last_len, 80 + 8 * SB);

    // Prescale 2 clamps to 4.
    send(8'h01, 1'b0, 1'b0, 6'd2);
    check("model len clamp", mq.size(), 36 + 4 * SB);
    repeat (2) @(negedge clk);
    check("clamp start", int'(tx_if.TX_OUT), 0);
    repeat (4) @(negedge clk);
    check("clamp bit0", int'(tx_if.TX_OUT), 1);
    repeat (4) @(negedge clk);
    check("clamp bit1", int'(tx_if.TX_OUT), 0);
    wait_idle("timeout clamp");
    check("busy len clamp", last_len, 36 + 4 * SB);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
